// File: rtl/gl_persp_div_seq.sv
// rtl/gl_persp_div_seq.sv - perspective-division sequencer sharing one external pipelined divider
module gl_persp_div_seq #(
   parameter int          DIV_LATENCY = 4,
   parameter logic [31:0] FLUSH_WORD  = 32'hFFFFFFFF
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   input  logic         in_flush,
   input  logic         in_bypass,
   input  logic [127:0] in_vertex,
   input  logic [95:0]  in_color,
   output logic         busy,
   output logic         div_issue,
   output logic [31:0]  div_a,
   output logic [31:0]  div_b,
   input  logic [31:0]  div_result,
   output logic [95:0]  out_vertex,
   output logic [95:0]  out_color,
   output logic         out_wr_en,
   input  logic         out_full
);

   // Counter must reach DIV_LATENCY+2, the z' capture cycle.
   localparam int CW = $clog2(DIV_LATENCY + 3);
   localparam logic [CW-1:0] CAP_X    = CW'(DIV_LATENCY);
   localparam logic [CW-1:0] CAP_Y    = CW'(DIV_LATENCY + 1);
   localparam logic [CW-1:0] CAP_Z    = CW'(DIV_LATENCY + 2);
   localparam logic [CW-1:0] LAST_ISS = CW'(2);
   localparam logic [31:0]   ONE_F    = 32'h3F800000;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_WRITE} state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [127:0]   vtx_q, vtx_d;
   logic [95:0]    out_vertex_q, out_vertex_d;
   logic [95:0]    out_color_q, out_color_d;

   // State, captured vertex, issue/capture counter and output holding registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         vtx_q        <= '0;
         out_vertex_q <= '0;
         out_color_q  <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         vtx_q        <= vtx_d;
         out_vertex_q <= out_vertex_d;
         out_color_q  <= out_color_d;
      end
   end

   // Next-state, divider operand muxing, quotient capture and FIFO write strobe.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      vtx_d        = vtx_q;
      out_vertex_d = out_vertex_q;
      out_color_d  = out_color_q;
      div_issue    = 1'b0;
      div_a        = 32'h0;
      div_b        = 32'h0;
      out_wr_en    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               vtx_d       = in_vertex;
               out_color_d = in_color;
               cnt_d       = '0;
               if (in_flush) begin
                  out_vertex_d = {3{FLUSH_WORD}};
                  out_color_d  = {3{FLUSH_WORD}};
                  state_d      = S_WRITE;
               end else if (in_bypass || (in_vertex[31:0] == ONE_F)) begin
                  out_vertex_d = in_vertex[127:32];
                  state_d      = S_WRITE;
               end else begin
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            div_issue = 1'b1;
            div_b     = vtx_q[31:0];
            case (cnt_q[1:0])
               2'd0:    div_a = vtx_q[127:96];
               2'd1:    div_a = vtx_q[95:64];
               default: div_a = vtx_q[63:32];
            endcase
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST_ISS) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CAP_Z) state_d = S_WRITE;
         end
         S_WRITE: begin
            out_wr_en = ~out_full;
            if (!out_full) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Quotients return in issue order; capture may overlap ISSUE for short latencies.
      if ((state_q == S_ISSUE) || (state_q == S_DRAIN)) begin
         if (cnt_q == CAP_X) out_vertex_d[95:64] = div_result;
         if (cnt_q == CAP_Y) out_vertex_d[63:32] = div_result;
         if (cnt_q == CAP_Z) out_vertex_d[31:0]  = div_result;
      end
   end

   assign busy       = (state_q != S_IDLE);
   assign out_vertex = out_vertex_q;
   assign out_color  = out_color_q;

endmodule

// File: tb/tb_gl_persp_div_seq.sv
// tb/tb_gl_persp_div_seq.sv - scoreboard bench for gl_persp_div_seq
module tb_gl_persp_div_seq;
   localparam int L = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid, in_flush, in_bypass;
   logic [127:0] in_vertex;
   logic [95:0]  in_color;
   logic         busy, div_issue, out_wr_en, out_full;
   logic [31:0]  div_a, div_b, div_result;
   logic [95:0]  out_vertex, out_color;

   gl_persp_div_seq #(.DIV_LATENCY(L), .FLUSH_WORD(32'hFFFFFFFF)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_flush(in_flush),
      .in_bypass(in_bypass), .in_vertex(in_vertex), .in_color(in_color),
      .busy(busy), .div_issue(div_issue), .div_a(div_a), .div_b(div_b),
      .div_result(div_result), .out_vertex(out_vertex), .out_color(out_color),
      .out_wr_en(out_wr_en), .out_full(out_full)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail = 0;
   int acc = 0;

   typedef struct {int cyc; logic [31:0] a; logic [31:0] b;} iss_t;
   typedef struct {int cyc; logic [95:0] v; logic [95:0] c;} wr_t;
   iss_t iq[$];
   wr_t  wq[$];

   // Hand-computed quotient table for the operands used below.
   function automatic logic [31:0] div_fn(input logic [31:0] a, input logic [31:0] b);
      case ({a, b})
         {32'h40800000, 32'h40000000}: return 32'h40000000;
         {32'h40000000, 32'h40000000}: return 32'h3F800000;
         {32'h3F800000, 32'h40000000}: return 32'h3F000000;
         {32'h41000000, 32'h40800000}: return 32'h40000000;
         {32'h40000000, 32'h40800000}: return 32'h3F000000;
         {32'h40800000, 32'h40800000}: return 32'h3F800000;
         {32'h41000000, 32'h40000000}: return 32'h40800000;
         {32'h41800000, 32'h40000000}: return 32'h41000000;
         {32'h40400000, 32'h40000000}: return 32'h3FC00000;
         default:                      return 32'h7FC00000;
      endcase
   endfunction

   // Fixed-latency divider model: result of cycle c appears during cycle c+L.
   logic [31:0] pipe [0:L];
   always @(negedge clk) begin
      for (int i = L; i > 0; i--) pipe[i] <= pipe[i-1];
      pipe[0] <= div_issue ? div_fn(div_a, div_b) : 32'h0;
   end
   assign div_result = pipe[L];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: pops expected issues and writes whenever the DUT presents them.
   always @(negedge clk) begin
      if (!reset) begin
         if (div_issue) begin
            if (iq.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_issue: got div_issue=1 a=%h expected no issue", div_a);
            end else begin
               iss_t e;
               e = iq.pop_front();
               chk("issue_cycle", 128'(cyc), 128'(e.cyc));
               chk("div_a", 128'(div_a), 128'(e.a));
               chk("div_b", 128'(div_b), 128'(e.b));
            end
         end else begin
            chk("idle_operands_zero", {64'h0, div_a, div_b}, 128'h0);
         end
         if (out_wr_en) begin
            if (wq.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_write: got out_wr_en=1 vertex=%h expected no write", out_vertex);
            end else begin
               wr_t w;
               w = wq.pop_front();
               chk("write_cycle", 128'(cyc), 128'(w.cyc));
               chk("out_vertex", 128'(out_vertex), 128'(w.v));
               chk("out_color", 128'(out_color), 128'(w.c));
            end
         end
      end
   end

   task automatic send(input logic fl, input logic bp, input logic [127:0] v, input logic [95:0] c);
      in_valid = 1'b1; in_flush = fl; in_bypass = bp; in_vertex = v; in_color = c;
      @(posedge clk); #1;
      acc = cyc;
   endtask

   task automatic to_rel(input int r);
      @(negedge clk);
      while (cyc - acc + 1 < r) @(negedge clk);
   endtask

   task automatic exp_issue(input int r, input logic [31:0] a, input logic [31:0] b);
      iss_t e;
      e.cyc = acc + r - 1; e.a = a; e.b = b;
      iq.push_back(e);
   endtask

   task automatic exp_write(input int r, input logic [95:0] v, input logic [95:0] c);
      wr_t w;
      w.cyc = acc + r - 1; w.v = v; w.c = c;
      wq.push_back(w);
   endtask

   task automatic exp_div_a(input int r0);
      exp_issue(r0,     32'h40800000, 32'h40000000);
      exp_issue(r0 + 1, 32'h40000000, 32'h40000000);
      exp_issue(r0 + 2, 32'h3F800000, 32'h40000000);
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_busy"}, 128'(busy), 128'h0);
      chk({name, "_div_issue"}, 128'(div_issue), 128'h0);
      chk({name, "_div_ab"}, {64'h0, div_a, div_b}, 128'h0);
      chk({name, "_out_vertex"}, 128'(out_vertex), 128'h0);
      chk({name, "_out_color"}, 128'(out_color), 128'h0);
      chk({name, "_out_wr_en"}, 128'(out_wr_en), 128'h0);
   endtask

   initial begin
      #20000;
      n_fail++;
      $display("FAIL watchdog: got timeout at cycle %0d expected completion", cyc);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_flush = 1'b0; in_bypass = 1'b0;
      in_vertex = '0; in_color = '0; out_full = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      reset = 1'b0;

      // Divide: (4,2,1)/2
      send(1'b0, 1'b0, {32'h40800000, 32'h40000000, 32'h3F800000, 32'h40000000}, 96'h11223344_55667788_99AABBCC);
      in_valid = 1'b0;
      exp_div_a(1);
      exp_write(8, {32'h40000000, 32'h3F800000, 32'h3F000000}, 96'h11223344_55667788_99AABBCC);
      to_rel(1); chk("div_busy_c1", 128'(busy), 128'h1);
      to_rel(8); chk("div_busy_c8", 128'(busy), 128'h1);
      to_rel(9); chk("div_busy_c9", 128'(busy), 128'h0);

      // w == 1.0 bypass
      send(1'b0, 1'b0, {32'h41200000, 32'h41400000, 32'h41600000, 32'h3F800000}, 96'hA1A1A1A1_B2B2B2B2_C3C3C3C3);
      in_valid = 1'b0;
      exp_write(1, {32'h41200000, 32'h41400000, 32'h41600000}, 96'hA1A1A1A1_B2B2B2B2_C3C3C3C3);
      to_rel(1); chk("w1_busy_c1", 128'(busy), 128'h1);
      to_rel(2); chk("w1_busy_c2", 128'(busy), 128'h0);

      // explicit bypass with w = 2.0
      send(1'b0, 1'b1, {32'h11111111, 32'h22222222, 32'h33333333, 32'h40000000}, 96'h44444444_55555555_66666666);
      in_valid = 1'b0; in_bypass = 1'b0;
      exp_write(1, {32'h11111111, 32'h22222222, 32'h33333333}, 96'h44444444_55555555_66666666);
      to_rel(2); chk("bp_busy_c2", 128'(busy), 128'h0);

      // flush beats bypass
      send(1'b1, 1'b1, {32'h40800000, 32'h40000000, 32'h3F800000, 32'h40000000}, 96'h0);
      in_valid = 1'b0; in_flush = 1'b0; in_bypass = 1'b0;
      exp_write(1, {3{32'hFFFFFFFF}}, {3{32'hFFFFFFFF}});
      to_rel(2); chk("fl_busy_c2", 128'(busy), 128'h0);

      // out_full held through cycles 8..12, with an ignored input in the window
      send(1'b0, 1'b0, {32'h40800000, 32'h40000000, 32'h3F800000, 32'h40000000}, 96'h0F0F0F0F_F0F0F0F0_12345678);
      in_valid = 1'b0;
      exp_div_a(1);
      exp_write(13, {32'h40000000, 32'h3F800000, 32'h3F000000}, 96'h0F0F0F0F_F0F0F0F0_12345678);
      to_rel(7); out_full = 1'b1;
      to_rel(8); chk("full_busy_c8", 128'(busy), 128'h1);
      to_rel(9); chk("full_busy_c9", 128'(busy), 128'h1);
      send_ignored();
      to_rel(10); chk("full_busy_c10", 128'(busy), 128'h1);
      to_rel(11); chk("full_busy_c11", 128'(busy), 128'h1);
      in_valid = 1'b0; in_bypass = 1'b0;
      to_rel(12); chk("full_busy_c12", 128'(busy), 128'h1);
      chk("full_wr_low_c12", 128'(out_wr_en), 128'h0);
      @(posedge clk); #1; out_full = 1'b0;
      to_rel(13); chk("full_busy_c13", 128'(busy), 128'h1);
      to_rel(14); chk("full_busy_c14", 128'(busy), 128'h0);

      // reset in cycle 5 of a divide, then a fresh vertex
      send(1'b0, 1'b0, {32'h40800000, 32'h40000000, 32'h3F800000, 32'h40000000}, 96'hDEADDEAD_DEADDEAD_DEADDEAD);
      in_valid = 1'b0;
      exp_div_a(1);
      to_rel(5);
      reset = 1'b1;
      #1;
      chk_all_zero("midreset");
      @(negedge clk);
      reset = 1'b0;
      send(1'b0, 1'b0, {32'h41000000, 32'h40000000, 32'h40800000, 32'h40800000}, 96'h01020304_05060708_090A0B0C);
      in_valid = 1'b0;
      exp_issue(1, 32'h41000000, 32'h40800000);
      exp_issue(2, 32'h40000000, 32'h40800000);
      exp_issue(3, 32'h40800000, 32'h40800000);
      exp_write(8, {32'h40000000, 32'h3F000000, 32'h3F800000}, 96'h01020304_05060708_090A0B0C);
      to_rel(9); chk("post_reset_busy_c9", 128'(busy), 128'h0);

      // back-to-back divides with in_valid held high
      send(1'b0, 1'b0, {32'h40800000, 32'h40000000, 32'h3F800000, 32'h40000000}, 96'hAAAA0001_AAAA0002_AAAA0003);
      in_vertex = {32'h41000000, 32'h41800000, 32'h40400000, 32'h40000000};
      in_color  = 96'hBBBB0001_BBBB0002_BBBB0003;
      exp_div_a(1);
      exp_write(8, {32'h40000000, 32'h3F800000, 32'h3F000000}, 96'hAAAA0001_AAAA0002_AAAA0003);
      exp_issue(10, 32'h41000000, 32'h40000000);
      exp_issue(11, 32'h41800000, 32'h40000000);
      exp_issue(12, 32'h40400000, 32'h40000000);
      exp_write(17, {32'h40800000, 32'h41000000, 32'h3FC00000}, 96'hBBBB0001_BBBB0002_BBBB0003);
      to_rel(9); chk("b2b_busy_c9", 128'(busy), 128'h0);
      @(posedge clk); #1; in_valid = 1'b0;
      to_rel(17); chk("b2b_busy_c17", 128'(busy), 128'h1);
      to_rel(18); chk("b2b_busy_c18", 128'(busy), 128'h0);

      repeat (4) @(negedge clk);
      chk("issue_queue_drained", 128'(iq.size()), 128'h0);
      chk("write_queue_drained", 128'(wq.size()), 128'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Presents a bypass vertex while the DUT is stalled; it must not be latched.
   task automatic send_ignored();
      in_valid  = 1'b1;
      in_bypass = 1'b1;
      in_vertex = {32'h41200000, 32'h41400000, 32'h41600000, 32'h40000000};
      in_color  = 96'h77777777_88888888_99999999;
   endtask

endmodule

// File: doc/gl_persp_div_seq.md
# gl_persp_div_seq

Perspective-division sequencer for the coordinate-transform clock domain. It takes one transformed vertex {x,y,z,w} plus its color and time-shares a single external pipelined floating-point divider to compute x/w, y/w and z/w. It then writes the divided vertex and color into the vertex/color FIFOs feeding the rasterizer, and stalls decode while a vertex is in flight. It also handles the pass-through (no divide) and end-of-stream flush-marker cases.

## Interface
- DIV_LATENCY, 4: fixed cycles from divider operand issue to its result on div_result; must be ≥1.
- FLUSH_WORD, 32'hFFFFFFFF: word replicated on every output field for a flush marker.

- clk  in  1  transform clock; all state on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  1  vertex/color present; sampled only when busy=0.
- in_flush  in  1  with in_valid: emit flush marker instead of vertex.
- in_bypass  in  1  with in_valid: skip division, pass x,y,z through.
- in_vertex  in  128  {x[127:96], y[95:64], z[63:32], w[31:0]}, IEEE-754 single.
- in_color  in  96  {r,g,b}.
- busy  out  1  stall to decode; high whenever state≠IDLE.
- div_issue  out  1  operands on div_a/div_b valid this cycle.
- div_a  out  32  dividend (x, y, then z).
- div_b  out  32  divisor (captured w).
- div_result  in  32  quotient; valid exactly DIV_LATENCY cycles after the matching issue cycle; no handshake.
- out_vertex  out  96  {x',y',z'} to vertex FIFO.
- out_color  out  96  {r,g,b} to color FIFO.
- out_wr_en  out  1  write strobe to both FIFOs.
- out_full  in  1  vertex_full | color_full.

## Operation
- States: IDLE, ISSUE, DRAIN, WRITE.
- IDLE: on in_valid:
  - Capture in_vertex and in_color.
  - in_flush=1 → load FLUSH_WORD into all out_vertex/out_color fields; go to WRITE.
  - Else in_bypass=1, or w==32'h3F800000 (1.0) → out_vertex={x,y,z}, out_color=color; go to WRITE.
  - Else go to ISSUE with idx=0.
  - Priority: flush > bypass > 1.0-bypass > divide.
- ISSUE: lasts 3 cycles. div_issue=1, div_b=w, div_a=x/y/z for idx=0/1/2. After idx=2, go to DRAIN.
- Capture: a cycle counter starts at the first issue cycle. In counter cycles DIV_LATENCY, +1 and +2, div_result is registered into x', y' and z' respectively. Capture continues while still in ISSUE when DIV_LATENCY<3.
- DRAIN: wait until the z' capture cycle; then go to WRITE.
- WRITE: out_wr_en = (state==WRITE) & ~out_full, combinational. Leave WRITE for IDLE on the cycle out_wr_en=1. Exactly one pulse per accepted input.
- When div_issue=0, div_a and div_b are 0.
- No arithmetic in this block; w=0, NaN and Inf are passed to the divider unchecked.
- out_vertex and out_color are registered and hold their value after WRITE until the next load.

## Timing
- Reset values: busy=0, div_issue=0, div_a=0, div_b=0, out_vertex=0, out_color=0, out_wr_en=0; state=IDLE; counter=0.
- Cycle numbering: cycle 0 = edge where in_valid is accepted.
- Divide path:
  - busy=1 from cycle 1.
  - Issues in cycles 1, 2, 3.
  - z' captured at end of cycle 3+DIV_LATENCY.
  - out_wr_en in cycle 4+DIV_LATENCY if out_full=0.
  - Back in IDLE, busy=0, at cycle 5+DIV_LATENCY. Next accept occurs on that cycle's edge.
  - Throughput: one vertex per DIV_LATENCY+5 cycles.
- Bypass/flush path: out_wr_en in cycle 1; busy=0 in cycle 2. Throughput: one per 2 cycles.
- out_full=1 during WRITE: remain in WRITE, data held, busy=1. Write occurs on the first cycle out_full=0.
- in_valid while busy=1: ignored, not latched. Decode holds it.
- Mid-operation reset: immediate return to IDLE with all outputs at reset values. Results still in the divider pipeline are discarded; because latency is fixed, the next vertex always captures its own results.

## Test plan
- Divide, DIV_LATENCY=4, divider model, x=40800000 (4.0), y=40000000, z=3F800000, w=40000000 (2.0):
  - div_issue in cycles 1–3 with div_b=40000000.
  - out_wr_en only in cycle 8.
  - out_vertex={40000000,3F800000,3F000000}; out_color = input color.
  - busy low in cycle 9.
- w=3F800000, and separately in_bypass=1 with w=40000000:
  - No div_issue.
  - out_vertex={x,y,z} unchanged; out_wr_en in cycle 1.
- in_flush=1 with in_bypass=1: out_vertex=out_color=all FFFFFFFF; out_wr_en in cycle 1; no div_issue.
- out_full held high cycles 8–12 on the divide vector above:
  - out_wr_en low in those cycles, busy high.
  - A second in_valid during that window is ignored.
  - Single out_wr_en in cycle 13; busy low in cycle 14.
- reset pulsed in cycle 5 of a divide:
  - All outputs 0 immediately; no out_wr_en.
  - The next vertex (x=41000000 (8.0), w=40800000 (4.0)) gives x'=40000000.
- in_valid held high with two divide vertices back-to-back: accepts at cycles 0 and 9; out_wr_en in cycles 8 and 17 with the correct, distinct results.
